// File: rtl/gmii_frame_tx.sv
// GMII frame transmitter: preamble, SFD, payload, zero pad to MIN_FRAME, FCS, then inter-frame gap.
// Define GMII_TX_FCS_EN to generate and append the CRC-32 FCS in hardware.
module gmii_frame_tx #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IFG_LEN      = 12,
    parameter int unsigned MIN_FRAME    = 60
) (
    input  logic       e_txc,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic [7:0] e_txd,
    output logic       e_txen,
    output logic       e_txer,
    output logic       busy,
    output logic [3:0] tx_state
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        PREAMBLE = 4'd1,
        SFD      = 4'd2,
        DATA     = 4'd3,
        PAD      = 4'd4,
        FCS      = 4'd5,
        IFG      = 4'd6,
        DRAIN    = 4'd7
    } state_t;

    localparam logic [4:0]  PRE_LAST = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0]  IFG_LAST = 5'(IFG_LEN - 1);
    localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME);
`ifdef GMII_TX_FCS_EN
    localparam state_t TAIL = FCS;
`else
    localparam state_t TAIL = IFG;
`endif

    state_t      state;
    logic [4:0]  cnt;
    logic [10:0] byte_cnt;
    logic [11:0] next_cnt;
    logic [10:0] byte_cnt_sat;

    // next_cnt keeps the carry so the PAD/FCS decision is exact at the 2047 boundary
    assign next_cnt     = {1'b0, byte_cnt} + 12'd1;
    assign byte_cnt_sat = next_cnt[11] ? byte_cnt : next_cnt[10:0];

    assign din_ready = (state == DATA) || (state == DRAIN);
    assign busy      = (state != IDLE);
    assign tx_state  = state;

`ifdef GMII_TX_FCS_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    // state selects what is driven on the next edge, so outputs lag state by one cycle
    always_ff @(posedge e_txc) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            byte_cnt <= '0;
            e_txd    <= '0;
            e_txen   <= 1'b0;
            e_txer   <= 1'b0;
`ifdef GMII_TX_FCS_EN
            crc      <= '1;
`endif
        end else begin
            e_txer <= 1'b0;
            case (state)
                IDLE: begin
                    e_txen   <= 1'b0;
                    e_txd    <= '0;
                    cnt      <= '0;
                    byte_cnt <= '0;
`ifdef GMII_TX_FCS_EN
                    crc      <= '1;
`endif
                    if (start) state <= PREAMBLE;
                end
                PREAMBLE: begin
                    e_txen <= 1'b1;
                    e_txd  <= 8'h55;
                    if (cnt == PRE_LAST) begin
                        cnt   <= '0;
                        state <= SFD;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                SFD: begin
                    e_txen <= 1'b1;
                    e_txd  <= 8'hD5;
                    state  <= DATA;
                end
                DATA: begin
                    e_txen <= 1'b1;
                    if (din_valid) begin
                        e_txd    <= din;
                        byte_cnt <= byte_cnt_sat;
`ifdef GMII_TX_FCS_EN
                        crc      <= crc_next(crc, din);
`endif
                        if (din_last) state <= (next_cnt < MIN_LEN) ? PAD : TAIL;
                    end else begin
                        // underrun: flag one error byte, then discard the rest of the payload
                        e_txer <= 1'b1;
                        e_txd  <= '0;
                        state  <= DRAIN;
                    end
                end
                PAD: begin
                    e_txen   <= 1'b1;
                    e_txd    <= '0;
                    byte_cnt <= byte_cnt_sat;
`ifdef GMII_TX_FCS_EN
                    crc      <= crc_next(crc, 8'h00);
`endif
                    if (next_cnt >= MIN_LEN) state <= TAIL;
                end
`ifdef GMII_TX_FCS_EN
                FCS: begin
                    e_txen <= 1'b1;
                    e_txd  <= ~crc[7:0];
                    crc    <= {8'hFF, crc[31:8]};
                    if (cnt == 5'd3) begin
                        cnt   <= '0;
                        state <= IFG;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
`endif
                IFG: begin
                    e_txen <= 1'b0;
                    e_txd  <= '0;
                    if (cnt == IFG_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DRAIN: begin
                    e_txen <= 1'b0;
                    e_txd  <= '0;
                    if (din_valid && din_last) begin
                        cnt   <= '0;
                        state <= IFG;
                    end
                end
                default: begin
                    e_txen <= 1'b0;
                    e_txd  <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gmii_frame_tx.sv
// Scoreboard bench for gmii_frame_tx: default instance plus a MIN_FRAME=0 instance for the check vector.
module tb_gmii_frame_tx;
    typedef logic [7:0] byte_q_t [$];

    localparam int PRE = 7;
`ifdef GMII_TX_FCS_EN
    localparam int FCS_BYTES = 4;
`else
    localparam int FCS_BYTES = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, start0, start1;
    logic [7:0] din;
    logic       din_valid, din_last;
    logic [7:0] txd [2];
    logic       txen [2];
    logic       txer [2];
    logic       rdy [2];
    logic       bsy [2];
    logic [3:0] st [2];

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q [$];
    int         len_q [$];
    int         gap_q [$];
    int         run_len [2];
    int         low_cnt [2];
    int         rdy_cnt [2];
    logic       prev_en [2];

    always #4 clk = ~clk;

    gmii_frame_tx #(.PREAMBLE_LEN(7), .IFG_LEN(12), .MIN_FRAME(60)) dut (
        .e_txc(clk), .reset(reset), .start(start0), .din(din), .din_valid(din_valid),
        .din_last(din_last), .din_ready(rdy[0]), .e_txd(txd[0]), .e_txen(txen[0]),
        .e_txer(txer[0]), .busy(bsy[0]), .tx_state(st[0]));

    gmii_frame_tx #(.PREAMBLE_LEN(7), .IFG_LEN(12), .MIN_FRAME(0)) dut0 (
        .e_txc(clk), .reset(reset), .start(start1), .din(din), .din_valid(din_valid),
        .din_last(din_last), .din_ready(rdy[1]), .e_txd(txd[1]), .e_txen(txen[1]),
        .e_txer(txer[1]), .busy(bsy[1]), .tx_state(st[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef GMII_TX_FCS_EN
    // bit-serial reflected CRC-32 reference
    function automatic logic [31:0] ref_crc(input byte_q_t b);
        logic [31:0] c;
        logic        fb;
        c = '1;
        foreach (b[k])
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[k][j];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        return ~c;
    endfunction
`endif

    task automatic push_frame(input byte_q_t pl, input int min_frame, input int underrun_at,
                              input int gap, input int cut);
        byte_q_t    body;
        logic [8:0] frm [$];
`ifdef GMII_TX_FCS_EN
        logic [31:0] fcs;
`endif
        for (int k = 0; k < PRE; k++) frm.push_back(9'h055);
        frm.push_back(9'h0D5);
        if (underrun_at >= 0) begin
            for (int k = 0; k < underrun_at; k++) frm.push_back({1'b0, pl[k]});
            frm.push_back(9'h100);
        end else begin
            body = pl;
            while (body.size() < min_frame) body.push_back(8'h00);
            foreach (body[k]) frm.push_back({1'b0, body[k]});
`ifdef GMII_TX_FCS_EN
            fcs = ref_crc(body);
            for (int k = 0; k < 4; k++) frm.push_back({1'b0, fcs[8*k +: 8]});
`endif
        end
        if (cut > 0) while (frm.size() > cut) void'(frm.pop_back());
        foreach (frm[k]) exp_q.push_back(frm[k]);
        len_q.push_back(frm.size());
        gap_q.push_back(gap);
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else start1 = v;
    endtask

    task automatic drive(input byte_q_t pl, input int sel, input int underrun_at,
                         input int pulse_at, input bit clear_start);
        int   i = 0;
        int   budget = 0;
        bit   dropped = 0;
        logic r;
        while (i < pl.size()) begin
            @(negedge clk);
            budget++;
            if (budget > 3000) begin
                tests++;
                fails++;
                $display("FAIL drive_timeout: got %0d bytes accepted expected %0d", i, pl.size());
                din_valid = 1'b0;
                return;
            end
            r = rdy[sel];
            if (pulse_at >= 0) set_start(sel, r && (i == pulse_at));
            if (clear_start && r) set_start(sel, 1'b0);
            if (r && i == underrun_at && !dropped) begin
                din_valid = 1'b0;
                din_last  = 1'b0;
                dropped   = 1'b1;
            end else begin
                din       = pl[i];
                din_valid = 1'b1;
                din_last  = (i == pl.size() - 1);
                if (r) i++;
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
        din_last  = 1'b0;
        if (pulse_at >= 0) set_start(sel, 1'b0);
    endtask

    task automatic wait_idle(input int sel);
        int n = 0;
        @(negedge clk);
        while ((bsy[sel] || exp_q.size() != 0) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 3000) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", bsy[sel], exp_q.size());
        end
    endtask

    // monitor: every e_txen cycle pops one expected {e_txer, e_txd}; edges check run length and gap
    initial begin
        for (int k = 0; k < 2; k++) begin
            run_len[k] = 0; low_cnt[k] = 0; rdy_cnt[k] = 0; prev_en[k] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (txen[k] === 1'b1) begin
                if (!prev_en[k]) begin
                    if (gap_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_frame: got start on inst %0d expected none", k);
                    end else begin
                        int g;
                        g = gap_q.pop_front();
                        if (g >= 0) check("ifg_gap", low_cnt[k], g);
                    end
                    run_len[k] = 0;
                end
                run_len[k]++;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_byte: got %0h expected no txen", txd[k]);
                end else begin
                    check("tx_byte", {23'd0, txer[k], txd[k]}, {23'd0, exp_q.pop_front()});
                end
            end else begin
                if (prev_en[k]) begin
                    if (len_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL frame_len: got %0d expected no frame", run_len[k]);
                    end else begin
                        check("frame_len", run_len[k], len_q.pop_front());
                    end
                    low_cnt[k] = 0;
                end
                low_cnt[k]++;
            end
            if (rdy[k] === 1'b1) rdy_cnt[k]++;
            prev_en[k] = txen[k];
        end
    end

    initial begin
        byte_q_t p, p2;
        int      n;
        int      cut;
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        din = '0; din_valid = 1'b0; din_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", txd[0], 8'h00);
        check("rst_txen", txen[0], 1'b0);
        check("rst_txer", txer[0], 1'b0);
        check("rst_ready", rdy[0], 1'b0);
        check("rst_busy", bsy[0], 1'b0);
        check("rst_state", st[0], 4'd0);
        reset = 1'b0;
        @(negedge clk);

        // check vector on the MIN_FRAME=0 instance, expectations written out by hand
        p = {};
        for (int k = 0; k < 9; k++) p.push_back(8'h31 + 8'(k));
        for (int k = 0; k < 7; k++) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        for (int k = 0; k < 9; k++) exp_q.push_back(9'h031 + 9'(k));
`ifdef GMII_TX_FCS_EN
        exp_q.push_back(9'h026); exp_q.push_back(9'h039);
        exp_q.push_back(9'h0F4); exp_q.push_back(9'h0CB);
        len_q.push_back(21);
`else
        len_q.push_back(17);
`endif
        gap_q.push_back(-1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        drive(p, 1, -1, -1, 0);
        wait_idle(1);

        // one-byte frame, padded to 60
        p = {8'hAB};
        rdy_cnt[0] = 0;
        push_frame(p, 60, -1, -1, 0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drive(p, 0, -1, -1, 0);
        wait_idle(0);
        check("one_byte_ready_cycles", rdy_cnt[0], 1);

        // back-to-back 100-byte frames with start held
        p = {}; p2 = {};
        for (int k = 0; k < 100; k++) begin
            p.push_back(8'(k));
            p2.push_back(8'hA0 ^ 8'(k));
        end
        push_frame(p, 60, -1, -1, 0);
        push_frame(p2, 60, -1, 13, 0);
        start0 = 1'b1;
        drive(p, 0, -1, -1, 0);
        drive(p2, 0, -1, -1, 1);
        wait_idle(0);

        // underrun after 20 bytes of a 64-byte stream
        p = {};
        for (int k = 0; k < 64; k++) p.push_back(8'(k * 3 + 1));
        push_frame(p, 60, 20, -1, 0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drive(p, 0, 20, -1, 0);
        n = 0;
        while (bsy[0] && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("underrun_ifg_cycles", n, 12);

        // start pulses during DATA and during IFG must be ignored
        p = {};
        for (int k = 0; k < 30; k++) p.push_back(8'hC0 + 8'(k));
        push_frame(p, 60, -1, -1, 0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drive(p, 0, -1, 5, 0);
        n = 0;
        while (txen[0] && n < 200) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (bsy[0] && n < 100) begin
            n++;
            start0 = (n == 3);
            @(negedge clk);
        end
        start0 = 1'b0;
        check("busy_through_ifg", n, 11);
        repeat (20) @(negedge clk);
        check("no_extra_frame_busy", bsy[0], 1'b0);

        // reset while the third-from-last frame byte is on the wire
        cut = PRE + 1 + 60 + FCS_BYTES;
        p = {8'hAB};
        push_frame(p, 60, -1, -1, cut - 2);
        start0 = 1'b1;
        din = 8'hAB; din_valid = 1'b1; din_last = 1'b1;
        for (int k = 1; k <= cut - 1; k++) begin
            @(negedge clk);
            if (k == 1) start0 = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midrst_txen", txen[0], 1'b0);
        check("midrst_txd", txd[0], 8'h00);
        check("midrst_txer", txer[0], 1'b0);
        check("midrst_state", st[0], 4'd0);
        check("midrst_busy", bsy[0], 1'b0);
        reset = 1'b0;
        din_valid = 1'b0; din_last = 1'b0;
        p = {8'h5A};
        push_frame(p, 60, -1, -1, 0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("post_rst_state", st[0], 4'd1);
        check("post_rst_txen_wait", txen[0], 1'b0);
        @(negedge clk);
        check("post_rst_preamble", {txen[0], txd[0]}, 9'h155);
        drive(p, 0, -1, -1, 0);
        wait_idle(0);

        repeat (4) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("len_q_empty", len_q.size(), 0);
        check("gap_q_empty", gap_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
